// File: rtl/gsm_egress_buf.sv
// Egress buffer between the switch egress port and the downstream consumer.
// First-word-fall-through FIFO with registered stall, sticky overflow and a delivered-word counter.
module gsm_egress_buf #(
    parameter int DWIDTH       = 128,
    parameter int AWIDTH       = 4,
    parameter int STALL_MARGIN = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_valid,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    input  logic              i_ready,
    output logic [AWIDTH:0]   o_count,
    output logic              o_overflow,
    output logic [31:0]       o_word_cnt
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL     = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] STALL_TH = (AWIDTH+1)'(DEPTH - STALL_MARGIN);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic              rd, wr;

    always_comb begin
        rd         = (count_q != '0) && i_ready;
        // A full buffer can still take a word when the head leaves in the same cycle.
        wr         = i_valid && ((count_q < FULL) || rd);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            word_cnt_d = word_cnt_q + 32'd1;
        end
        case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (i_valid && !wr) overflow_d = 1'b1;
        stall_d = (count_d >= STALL_TH);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Storage is not reset; an entry written while clr is high is unreachable since pointers and count clear.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_valid    = (count_q != '0);
    assign o_data     = mem_q[rd_ptr_q];
    assign o_count    = count_q;
    assign o_stall    = stall_q;
    assign o_overflow = overflow_q;
    assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_gsm_egress_buf.sv
// Bench for gsm_egress_buf: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional clr.
module tb_gsm_egress_buf;

    localparam int DWIDTH = 128;
    localparam int AWIDTH = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              i_valid = 1'b0;
    logic [DWIDTH-1:0] i_data = '0;
    logic              i_ready = 1'b0;
    logic              o_stall, o_valid, o_overflow;
    logic [DWIDTH-1:0] o_data;
    logic [AWIDTH:0]   o_count;
    logic [31:0]       o_word_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gsm_egress_buf #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .STALL_MARGIN(3)) dut (
        .clk(clk), .clr(clr), .i_valid(i_valid), .i_data(i_data),
        .o_stall(o_stall), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_count(o_count), .o_overflow(o_overflow),
        .o_word_cnt(o_word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer as a plain queue.
    logic [DWIDTH-1:0] mq[$];
    bit                m_ovf;
    bit                m_stall;
    int unsigned       m_wcnt;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_stall = 1'b0;
            m_wcnt  = 0;
        end else begin
            automatic bit do_rd = (mq.size() != 0) && i_ready;
            automatic bit do_wr = i_valid && ((mq.size() < DEPTH) || do_rd);
            if (do_rd) begin
                void'(mq.pop_front());
                m_wcnt = m_wcnt + 1;
            end
            if (do_wr) mq.push_back(i_data);
            else if (i_valid) m_ovf = 1'b1;
            m_stall = (mq.size() >= DEPTH - 3);
        end
    end

    task automatic chk(input string nm, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            chk("m_valid", 128'(o_valid), 128'(mq.size() != 0));
            if (mq.size() != 0) chk("m_data", o_data, mq[0]);
            chk("m_count", 128'(o_count), 128'(mq.size()));
            chk("m_stall", 128'(o_stall), 128'(m_stall));
            chk("m_ovf", 128'(o_overflow), 128'(m_ovf));
            chk("m_wcnt", 128'(o_word_cnt), 128'(m_wcnt));
        end
    end

    task automatic drive(input bit v, input logic [DWIDTH-1:0] d, input bit r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 128'(o_valid), '0);
        chk({nm, "_count"}, 128'(o_count), '0);
        chk({nm, "_stall"}, 128'(o_stall), '0);
        chk({nm, "_ovf"}, 128'(o_overflow), '0);
        chk({nm, "_wcnt"}, 128'(o_word_cnt), '0);
    endtask

    task automatic pulse_clr();
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2 clr = 1'b1;
        #1 chk_zero("clr_async");
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    initial begin
        int pv, pr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 clr = 1'b0;

        // single word
        drive(1, 128'hA5, 0);
        chk("single_valid", 128'(o_valid), 128'd1);
        chk("single_data", o_data, 128'hA5);
        chk("single_count", 128'(o_count), 128'd1);
        drive(0, '0, 1);
        chk("single_empty", 128'(o_valid), 128'd0);
        chk("single_wcnt", 128'(o_word_cnt), 128'd1);

        // stall threshold
        for (int i = 0; i < 12; i++) drive(1, 128'(i + 16'h200), 0);
        chk("stall_at12", 128'(o_stall), 128'd0);
        drive(1, 128'h20C, 0);
        chk("stall_count13", 128'(o_count), 128'd13);
        chk("stall_at13", 128'(o_stall), 128'd1);
        drive(0, '0, 1);
        chk("stall_count12", 128'(o_count), 128'd12);
        chk("stall_release", 128'(o_stall), 128'd0);
        for (int i = 0; i < 12; i++) drive(0, '0, 1);

        // overflow
        for (int i = 1; i <= 17; i++) drive(1, 128'(i), 0);
        chk("ovf_count", 128'(o_count), 128'd16);
        chk("ovf_flag", 128'(o_overflow), 128'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain", o_data, 128'(i + 1));
            drive(0, '0, 1);
        end
        chk("ovf_drained", 128'(o_valid), 128'd0);
        chk("ovf_sticky", 128'(o_overflow), 128'd1);

        // full with simultaneous read and write
        pulse_clr();
        for (int i = 1; i <= 16; i++) drive(1, 128'(i), 0);
        drive(1, 128'h99, 1);
        chk("full_rw_count", 128'(o_count), 128'd16);
        chk("full_rw_ovf", 128'(o_overflow), 128'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 0)  chk("full_rw_first", o_data, 128'd2);
            if (i == 15) chk("full_rw_last", o_data, 128'h99);
            drive(0, '0, 1);
        end

        // wrap-around streaming
        pulse_clr();
        for (int i = 0; i < 40; i++) begin
            drive(1, 128'(i + 16'h1000), 1);
            chk("wrap_le1", 128'(o_count <= 1), 128'd1);
        end
        drive(0, '0, 1);
        chk("wrap_wcnt", 128'(o_word_cnt), 128'd40);
        chk("wrap_empty", 128'(o_valid), 128'd0);

        // reset mid-operation
        for (int i = 0; i < 17; i++) drive(1, 128'(i), 0);
        for (int i = 0; i < 9; i++) drive(0, '0, 1);
        chk("mid_count7", 128'(o_count), 128'd7);
        chk("mid_ovf", 128'(o_overflow), 128'd1);
        pulse_clr();
        drive(1, 128'h3C, 0);
        chk("mid_first_valid", 128'(o_valid), 128'd1);
        chk("mid_first_data", o_data, 128'h3C);

        // randomized traffic
        pv = 50;
        pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pv = 10 + 40 * $urandom_range(0, 2);
                pr = 10 + 40 * $urandom_range(0, 2);
            end
            if ($urandom_range(0, 399) == 0) pulse_clr();
            drive($urandom_range(0, 99) < pv, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 99) < pr);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
